// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control unit: state codes and default
// timing parameters for the button debouncers.
package stopwatch_pkg;

    localparam logic [1:0] ST_STOP  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;

    localparam int SAMPLE_DIV_DEF = 100_000;
    localparam int DB_DEPTH_DEF   = 8;

endpackage

// File: rtl/btn_debounce.sv
// One push-button path: two-flop synchroniser, tick-sampled shift register,
// debounced level with hysteresis, and a single-clk rising-edge pulse.
module btn_debounce #(
    parameter int DB_DEPTH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic btn,
    output logic o_level,
    output logic o_edge
);

    logic                sync_p0;
    logic                sync_p1;
    logic [DB_DEPTH-1:0] samples;
    logic [DB_DEPTH-1:0] samples_nxt;
    logic                level;
    logic                level_prev;
    logic                edge_q;

    assign samples_nxt = {samples[DB_DEPTH-2:0], sync_p1};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_p0    <= 1'b0;
            sync_p1    <= 1'b0;
            samples    <= '0;
            level      <= 1'b0;
            level_prev <= 1'b0;
            edge_q     <= 1'b0;
        end else begin
            sync_p0    <= btn;
            sync_p1    <= sync_p0;
            // Level only moves on a unanimous window; mixed samples hold it.
            if (tick) begin
                samples <= samples_nxt;
                if (&samples_nxt)
                    level <= 1'b1;
                else if (~|samples_nxt)
                    level <= 1'b0;
            end
            level_prev <= level;
            edge_q     <= level & ~level_prev;
        end
    end

    assign o_level = level;
    assign o_edge  = edge_q;

endmodule

// File: rtl/stopwatch_cu.sv
// Stopwatch control unit: debounces the run/stop and clear buttons and runs a
// STOP/RUN/CLEAR Moore FSM whose state directly drives the datapath controls.
module stopwatch_cu
    import stopwatch_pkg::*;
#(
    parameter int SAMPLE_DIV = SAMPLE_DIV_DEF,
    parameter int DB_DEPTH   = DB_DEPTH_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_run,
    input  logic       btn_clear,
    output logic       run,
    output logic       clear,
    output logic [1:0] o_state
);

    localparam int               CNT_W   = $clog2(SAMPLE_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SAMPLE_DIV - 1);

    logic [CNT_W-1:0] tick_cnt;
    logic             tick;
    logic             run_level;
    logic             run_edge;
    logic             clr_level;
    logic             clr_edge;
    logic [1:0]       state;
    logic [1:0]       state_nxt;

    assign tick = (tick_cnt == CNT_MAX);

    // One free-running sample counter shared by both buttons.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + 1'b1;
    end

    btn_debounce #(.DB_DEPTH(DB_DEPTH)) u_db_run (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .btn     (btn_run),
        .o_level (run_level),
        .o_edge  (run_edge)
    );

    btn_debounce #(.DB_DEPTH(DB_DEPTH)) u_db_clear (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .btn     (btn_clear),
        .o_level (clr_level),
        .o_edge  (clr_edge)
    );

    // Clear wins over run in STOP; CLEAR always falls back to STOP and drops
    // any edge that lands in that cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_STOP: begin
                if (clr_edge)
                    state_nxt = ST_CLEAR;
                else if (run_edge)
                    state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (run_edge)
                    state_nxt = ST_STOP;
            end
            ST_CLEAR: state_nxt = ST_STOP;
            default:  state_nxt = ST_STOP;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= ST_STOP;
        else
            state <= state_nxt;
    end

    assign run     = (state == ST_RUN);
    assign clear   = (state == ST_CLEAR);
    assign o_state = state;

    logic unused_levels;
    assign unused_levels = run_level ^ clr_level;

endmodule

// File: tb/tb_stopwatch_cu.sv
// Directed bench for stopwatch_cu with SAMPLE_DIV=4, DB_DEPTH=4.
module tb_stopwatch_cu;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_run;
    logic       btn_clear;
    logic       run;
    logic       clear;
    logic [1:0] o_state;

    int checks = 0;
    int errors = 0;

    int run_rises    = 0;
    int clear_cycles = 0;
    int run_edges    = 0;
    logic run_prev   = 1'b0;

    stopwatch_cu #(.SAMPLE_DIV(4), .DB_DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_run   (btn_run),
        .btn_clear (btn_clear),
        .run       (run),
        .clear     (clear),
        .o_state   (o_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        run_prev <= run;
        if (run && !run_prev)
            run_rises <= run_rises + 1;
        if (clear)
            clear_cycles <= clear_cycles + 1;
        if (dut.u_db_run.o_edge)
            run_edges <= run_edges + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_run(input string tag, input logic val, input int budget);
        int n = 0;
        while (run !== val && n < budget) begin
            step(1);
            n++;
        end
        check(tag, run, val);
    endtask

    task automatic wait_clear(input string tag, input int budget);
        int n = 0;
        while (clear !== 1'b1 && n < budget) begin
            step(1);
            n++;
        end
        check(tag, clear, 1'b1);
    endtask

    int snap_a;
    int snap_b;

    initial begin
        reset     = 1'b0;
        btn_run   = 1'b1;
        btn_clear = 1'b1;
        step(6);

        // 1. reset values with both buttons pressed
        check("rst_run", run, 1'b0);
        check("rst_clear", clear, 1'b0);
        check("rst_state", o_state, 2'd0);

        // 5. release reset with both held: same-cycle edges, clear wins
        snap_a = run_rises;
        reset = 1'b1;
        wait_clear("both_clear", 25);
        check("both_state2", o_state, 2'd2);
        step(1);
        check("both_clear_off", clear, 1'b0);
        check("both_state0", o_state, 2'd0);
        step(30);
        check("both_no_run", run_rises - snap_a, 0);
        btn_run = 1'b0;
        btn_clear = 1'b0;
        step(30);

        // 2. start/stop
        btn_run = 1'b1;
        wait_run("start", 1'b1, 20);
        step(20);
        check("start_hold", run, 1'b1);
        btn_run = 1'b0;
        step(30);
        check("after_release", run, 1'b1);
        btn_run = 1'b1;
        wait_run("stop", 1'b0, 20);
        check("stop_state", o_state, 2'd0);
        step(20);
        btn_run = 1'b0;
        step(30);

        // 3. bounce rejection: 3 clk high / 5 clk low
        snap_a = run_edges;
        for (int i = 0; i < 100; i++) begin
            btn_run = ((i % 8) < 3);
            step(1);
        end
        btn_run = 1'b0;
        step(30);
        check("bounce_run", run, 1'b0);
        check("bounce_edges", run_edges - snap_a, 0);

        // 4a. clear in STOP
        snap_b = clear_cycles;
        btn_clear = 1'b1;
        wait_clear("clr_pulse", 25);
        check("clr_state2", o_state, 2'd2);
        check("clr_run_low", run, 1'b0);
        step(1);
        check("clr_off", clear, 1'b0);
        check("clr_state0", o_state, 2'd0);
        step(20);
        check("clr_width", clear_cycles - snap_b, 1);
        btn_clear = 1'b0;
        step(30);

        // 4b. clear ignored in RUN
        btn_run = 1'b1;
        wait_run("run_again", 1'b1, 20);
        btn_run = 1'b0;
        step(30);
        snap_b = clear_cycles;
        btn_clear = 1'b1;
        step(40);
        check("run_clr_ign", clear_cycles - snap_b, 0);
        check("run_clr_run", run, 1'b1);
        check("run_clr_state", o_state, 2'd1);
        btn_clear = 1'b0;
        step(30);

        // 6. reset mid-operation with btn_run held through release
        btn_run = 1'b1;
        step(4);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_run", run, 1'b0);
        check("async_rst_state", o_state, 2'd0);
        step(5);
        snap_a = run_rises;
        reset = 1'b1;
        wait_run("post_rst_run", 1'b1, 25);
        step(60);
        check("post_rst_once", run_rises - snap_a, 1);
        check("post_rst_hold", run, 1'b1);
        btn_run = 1'b0;
        step(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stopwatch_cu.md
# stopwatch_cu

Control unit for the stopwatch datapath: it turns the two raw push-button inputs (run/stop and clear) into the `run` and `clear` levels consumed by the stopwatch datapath. Each button is synchronised, debounced and edge-detected. A three-state Moore FSM (STOP, RUN, CLEAR) then drives the control outputs. It sits between the board button pins and the stopwatch datapath, in the same clock domain.

## Interface
Parameters:
- `SAMPLE_DIV`, 100_000: clk cycles per debounce sample tick (1 kHz at 100 MHz); minimum 2.
- `DB_DEPTH`, 8: consecutive equal samples required to change the debounced level; minimum 2.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `btn_run`  in  1  raw run/stop button, active-high, asynchronous to `clk`.
- `btn_clear`  in  1  raw clear button, active-high, asynchronous to `clk`.
- `run`  out  1  high while in RUN; drives datapath `run`.
- `clear`  out  1  high for exactly one clk while in CLEAR; drives datapath `clear`.
- `o_state`  out  2  current state code for status LEDs: STOP=0, RUN=1, CLEAR=2.

## Operation
- **Per-button path:** 2-FF synchroniser, then a shift register sampled on the shared sample tick, then the debounced level, then a rising-edge pulse.
- **Sample tick:** a free-running counter from 0 to `SAMPLE_DIV`-1 emits a 1-clk tick on wrap. Both buttons share this counter.
- **Debounced level:**
  - becomes 1 when the last `DB_DEPTH` samples are all 1;
  - becomes 0 when they are all 0;
  - otherwise holds its value.
- **Edge pulse:** 1 clk wide, asserted on the cycle after the debounced level goes 0→1. Releases generate no event.
- **FSM transitions, evaluated on edge pulses:**
  - STOP + clear edge → CLEAR. Clear has priority when both edges arrive in the same cycle.
  - STOP + run edge → RUN.
  - RUN + run edge → STOP. A clear edge in RUN is ignored.
  - CLEAR → STOP unconditionally on the next clk. Edges arriving in that cycle are discarded.
- **Outputs:** decoded directly from the state register (Moore), so they are glitch-free.
  - `run` = (state==RUN).
  - `clear` = (state==CLEAR).
  - `o_state` = state code.
- Holding a button produces exactly one event. A new event needs a full release (debounced 0) followed by a press.

## Timing
- **Reset** (`reset`=0, async): state=STOP; synchronisers, sample shift registers, debounced levels, edge pulses and the tick counter all 0. Outputs: `run`=0, `clear`=0, `o_state`=0. Release is synchronous in effect; the first tick arrives `SAMPLE_DIV` clks after release.
- **Press-to-output latency** for a clean step: 2 clk (synchroniser), plus the wait until `DB_DEPTH` ticks have sampled 1 (between (`DB_DEPTH`-1)·`SAMPLE_DIV`+1 and `DB_DEPTH`·`SAMPLE_DIV` clks), plus 1 clk (edge), plus 1 clk (state register).
- **Bounce:** a glitch shorter than `DB_DEPTH` consecutive samples never changes the debounced level.
- **`clear` pulse:** exactly 1 clk wide. `run` is 0 throughout the CLEAR cycle and after it.
- **Reset mid-operation:** the FSM returns to STOP immediately. A button still held when reset is released must pass through debounce again; because the level restarts at 0, a held button does generate one press event after reset.

## Structure
- **Shared package `stopwatch_pkg`:**
  - state encoding localparams `ST_STOP`=2'd0, `ST_RUN`=2'd1, `ST_CLEAR`=2'd2;
  - default `SAMPLE_DIV` and `DB_DEPTH`.
- **Sub-module `btn_debounce`:** synchroniser, sample shift register, debounced level and edge pulse. It takes `clk`, `reset` and the sample tick, and outputs `o_level` and `o_edge`. `stopwatch_cu` instantiates it twice and owns the single tick counter and the FSM.

## Test plan
Benches use `SAMPLE_DIV`=4 and `DB_DEPTH`=4.
1. **Reset values:** hold `reset`=0 with both buttons high → `run`=0, `clear`=0, `o_state`=0. After release and steady presses, the first events are processed normally.
2. **Start/stop:** clean `btn_run` press held for 40 clks → `run` rises within 2+16+2 clks and stays high. Release, then press again → `run` falls and `o_state`=0.
3. **Bounce rejection:** toggle `btn_run` with high times of 3 clks and low times of 5 clks for 100 clks → `run` stays 0, and `o_edge` never asserts.
4. **Clear:** in STOP, press `btn_clear` → `clear` high for exactly 1 clk with `o_state`=2, then `o_state`=0. In RUN, a `btn_clear` press → `clear` stays 0 and `run` stays 1.
5. **Simultaneous presses:** in STOP, press both buttons on the same clk → one `clear` pulse, then STOP. `run` never asserts.
6. **Reset mid-operation:** assert `reset` while in RUN → `run`=0 asynchronously within the same clk. Keep `btn_run` held through reset release → exactly one RUN entry after debounce.
